// File: rtl/vga_sync_gen_pkg.sv
// Screen timing constants used by the sync generator, pixel generation and sprite logic.
// Helper functions derive the wrap points and sync pulse bounds from the porch values.
package vga_sync_gen_pkg;

    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = (1 << COORD_W) - 1;

    localparam int VGA_HD  = 640;
    localparam int VGA_HF  = 16;
    localparam int VGA_HB  = 48;
    localparam int VGA_HR  = 96;
    localparam int VGA_VD  = 480;
    localparam int VGA_VF  = 10;
    localparam int VGA_VB  = 33;
    localparam int VGA_VR  = 2;
    localparam int VGA_DIV = 4;

    function automatic int span_max(input int disp, input int fp, input int bp, input int retr);
        return disp + fp + bp + retr - 1;
    endfunction

    function automatic int sync_start(input int disp, input int fp);
        return disp + fp;
    endfunction

    function automatic int sync_end(input int disp, input int fp, input int retr);
        return disp + fp + retr - 1;
    endfunction

    localparam int VGA_HMAX     = span_max(VGA_HD, VGA_HF, VGA_HB, VGA_HR);
    localparam int VGA_VMAX     = span_max(VGA_VD, VGA_VF, VGA_VB, VGA_VR);
    localparam int VGA_HS_START = sync_start(VGA_HD, VGA_HF);
    localparam int VGA_HS_END   = sync_end(VGA_HD, VGA_HF, VGA_HR);
    localparam int VGA_VS_START = sync_start(VGA_VD, VGA_VF);
    localparam int VGA_VS_END   = sync_end(VGA_VD, VGA_VF, VGA_VR);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Coordinate / sync bundle between the timing generator (master) and pixel colour logic (slave).
interface vga_sync_gen_if;
    import vga_sync_gen_pkg::*;

    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               p_tick;
    logic               frame_start;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;

    modport master (output hsync, vsync, video_on, p_tick, frame_start, x, y);
    modport slave  (input  hsync, vsync, video_on, p_tick, frame_start, x, y);

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Mod-DIV counter; tick is high during the last clock of every pixel period.
module pixel_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk_100MHz,
    input  logic reset,
    output logic tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_div_cnt;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == C_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign tick = (r_div_cnt == C_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters plus registered sync, video_on and frame_start
// decodes, all taken from the next-count values so every output moves on the same edge.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int HD  = VGA_HD,
    parameter int HF  = VGA_HF,
    parameter int HB  = VGA_HB,
    parameter int HR  = VGA_HR,
    parameter int VD  = VGA_VD,
    parameter int VF  = VGA_VF,
    parameter int VB  = VGA_VB,
    parameter int VR  = VGA_VR,
    parameter int DIV = VGA_DIV
) (
    input  logic           clk_100MHz,
    input  logic           reset,
    vga_sync_gen_if.master bus
);

    typedef logic [COORD_W-1:0] coord_t;

    localparam int     HMAX       = span_max(HD, HF, HB, HR);
    localparam int     VMAX       = span_max(VD, VF, VB, VR);
    localparam coord_t C_HMAX     = coord_t'(HMAX);
    localparam coord_t C_VMAX     = coord_t'(VMAX);
    localparam coord_t C_HD       = coord_t'(HD);
    localparam coord_t C_VD       = coord_t'(VD);
    localparam coord_t C_HS_START = coord_t'(sync_start(HD, HF));
    localparam coord_t C_HS_END   = coord_t'(sync_end(HD, HF, HR));
    localparam coord_t C_VS_START = coord_t'(sync_start(VD, VF));
    localparam coord_t C_VS_END   = coord_t'(sync_end(VD, VF, VR));

    generate
        if (HMAX > COORD_LIMIT || VMAX > COORD_LIMIT) begin : g_bad_timing
            $error("vga_sync_gen: HMAX/VMAX exceed the 10-bit coordinate range");
        end
    endgenerate

    logic   w_tick;
    coord_t w_x_next;
    coord_t w_y_next;
    coord_t r_x;
    coord_t r_y;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;
    logic   r_p_tick;
    logic   r_frame_start;

    pixel_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick       (w_tick)
    );

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (r_x == C_HMAX) begin
                w_x_next = '0;
                w_y_next = (r_y == C_VMAX) ? '0 : r_y + 1'b1;
            end else begin
                w_x_next = r_x + 1'b1;
            end
        end
    end

    // Decodes update every clock, so video_on rises on the first edge after reset release.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_p_tick      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= !((w_x_next >= C_HS_START) && (w_x_next <= C_HS_END));
            r_vsync       <= !((w_y_next >= C_VS_START) && (w_y_next <= C_VS_END));
            r_video_on    <= (w_x_next < C_HD) && (w_y_next < C_VD);
            r_p_tick      <= w_tick;
            r_frame_start <= w_tick && (w_x_next == '0) && (w_y_next == '0);
        end
    end

    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.video_on    = r_video_on;
    assign bus.p_tick      = r_p_tick;
    assign bus.frame_start = r_frame_start;

endmodule
